// File: rtl/sine_dds_gen_if.sv
// Sample-stream bundle between the tick/control side and the DDS core.
// The master drives control and phase words; the slave returns samples.
interface sine_dds_gen_if #(
    parameter int PHASE_WIDTH = 16,
    parameter int DATA_WIDTH  = 12
);
    logic                          en;
    logic                          clr;
    logic        [PHASE_WIDTH-1:0] tuning_word;
    logic        [PHASE_WIDTH-1:0] phase_offset;
    logic signed [DATA_WIDTH-1:0]  sample;
    logic                          valid;
    logic                          cycle;

    modport master (
        output en, clr, tuning_word, phase_offset,
        input  sample, valid, cycle
    );

    modport slave (
        input  en, clr, tuning_word, phase_offset,
        output sample, valid, cycle
    );
endinterface

// File: rtl/sine_dds_gen.sv
// DDS sine generator: phase accumulator, quarter-wave table, quadrant fold.
// The quarter-wave table is computed at elaboration from the half-step formula.
module sine_dds_gen #(
    parameter int PHASE_WIDTH = 16,
    parameter int ADDR_WIDTH  = 6,
    parameter int DATA_WIDTH  = 12
) (
    input logic            clk,
    input logic            rst,
    sine_dds_gen_if.slave  dds
);
    localparam int N   = 1 << ADDR_WIDTH;
    localparam int IW  = ADDR_WIDTH + 2;
    localparam int RW  = DATA_WIDTH - 1;
    localparam int AMP = (1 << (DATA_WIDTH - 1)) - 1;

    function automatic logic [RW-1:0] rom_word(input int k);
        real x;
        x = real'(AMP) * $sin(3.14159265358979 / 2.0 * (real'(k) + 0.5) / real'(N));
        return RW'($rtoi(x + 0.5));
    endfunction

    logic [RW-1:0] rom [N];

    for (genvar k = 0; k < N; k++) begin : g_rom
        localparam logic [RW-1:0] W = rom_word(k);
        assign rom[k] = W;
    end

    logic        [PHASE_WIDTH-1:0] acc_q, acc_d;
    logic                          wrap_q, wrap_d;
    logic                          v1_q;
    logic        [RW-1:0]          rom_q;
    logic                          neg_q;
    logic                          cyc1_q;
    logic signed [DATA_WIDTH-1:0]  sample_q;
    logic                          valid_q;
    logic                          cycle_q;

    logic        [PHASE_WIDTH:0]   sum;
    logic        [IW-1:0]          idx;
    logic        [1:0]             quad;
    logic        [ADDR_WIDTH-1:0]  addr;
    logic signed [DATA_WIDTH-1:0]  mag;

    assign sum    = {1'b0, acc_q} + {1'b0, dds.tuning_word};
    assign acc_d  = sum[PHASE_WIDTH-1:0];
    assign wrap_d = sum[PHASE_WIDTH];
    assign idx    = IW'((acc_q + dds.phase_offset) >> (PHASE_WIDTH - IW));
    assign quad   = idx[IW-1 -: 2];
    // Odd quadrants read the table backwards: N-1-k is just ~k.
    assign addr   = quad[0] ? ~idx[ADDR_WIDTH-1:0] : idx[ADDR_WIDTH-1:0];
    assign mag    = $signed({1'b0, rom_q});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            wrap_q   <= 1'b0;
            v1_q     <= 1'b0;
            rom_q    <= '0;
            neg_q    <= 1'b0;
            cyc1_q   <= 1'b0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            cycle_q  <= 1'b0;
        end else if (dds.clr) begin
            acc_q   <= '0;
            wrap_q  <= 1'b0;
            v1_q    <= 1'b0;
            valid_q <= 1'b0;
            cycle_q <= 1'b0;
        end else begin
            v1_q    <= dds.en;
            valid_q <= v1_q;
            cycle_q <= v1_q & cyc1_q;
            if (dds.en) begin
                acc_q  <= acc_d;
                wrap_q <= wrap_d;
                rom_q  <= rom[addr];
                neg_q  <= quad[1];
                cyc1_q <= wrap_q;
            end
            if (v1_q) begin
                sample_q <= neg_q ? -mag : mag;
            end
        end
    end

    assign dds.sample = sample_q;
    assign dds.valid  = valid_q;
    assign dds.cycle  = cycle_q;
endmodule

// File: tb/tb_sine_dds_gen.sv
// Bench for sine_dds_gen: directed scenarios plus random traffic,
// every cycle compared against a sine-formula reference with due-cycle scheduling.
module tb_sine_dds_gen;
    localparam int PW = 16;
    localparam int DW = 12;
    localparam real PI = 3.14159265358979;

    logic clk = 1'b0;
    logic rst;

    sine_dds_gen_if #(.PHASE_WIDTH(PW), .DATA_WIDTH(DW)) dds ();

    sine_dds_gen #(.PHASE_WIDTH(PW), .ADDR_WIDTH(6), .DATA_WIDTH(DW)) dut (
        .clk(clk),
        .rst(rst),
        .dds(dds)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int pulses = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: ideal sine at the centre of each of 256 phase bins.
    function automatic int ref_sample(input int idx);
        real x;
        x = 2047.0 * $sin(2.0 * PI * (real'(idx) + 0.5) / 256.0);
        return int'(x);
    endfunction

    int  exp_s [int];
    bit  exp_c [int];
    int  cyc = 0;
    int  m_acc = 0;
    bit  m_wrap = 1'b0;
    int  last_s = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_s.delete();
            exp_c.delete();
            m_acc  = 0;
            m_wrap = 1'b0;
            last_s = 0;
        end else begin
            if (dds.clr) begin
                exp_s.delete(cyc + 1);
                exp_c.delete(cyc + 1);
                m_acc  = 0;
                m_wrap = 1'b0;
            end else if (dds.en) begin
                int p;
                p = (m_acc + int'(dds.phase_offset)) % 65536;
                exp_s[cyc + 2] = ref_sample(p / 256);
                exp_c[cyc + 2] = m_wrap;
                m_acc  = m_acc + int'(dds.tuning_word);
                m_wrap = (m_acc >= 65536);
                m_acc  = m_acc % 65536;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            int ev;
            int ec;
            ev = 0;
            ec = 0;
            if (exp_s.exists(cyc)) begin
                last_s = exp_s[cyc];
                ev = 1;
                ec = int'(exp_c[cyc]);
            end
            chk("valid", int'(dds.valid), ev);
            chk("sample", int'(dds.sample), last_s);
            chk("cycle", int'(dds.cycle), ec);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (dds.valid && dds.cycle) pulses++;
    endtask

    initial begin
        rst = 1'b1;
        dds.en = 1'b0;
        dds.clr = 1'b0;
        dds.tuning_word = '0;
        dds.phase_offset = '0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_sample", int'(dds.sample), 0);
        chk("rst_valid", int'(dds.valid), 0);

        // Single en after reset: phase-0 sample two clocks later.
        dds.tuning_word = 16'd256;
        dds.en = 1'b1;
        step();
        dds.en = 1'b0;
        step();
        chk("t1_valid", int'(dds.valid), 1);
        chk("t1_sample", int'(dds.sample), 25);
        chk("t1_cycle", int'(dds.cycle), 0);

        dds.en = 1'b1;
        repeat (20) step();
        rst = 1'b1;
        #1;
        chk("midrst_sample", int'(dds.sample), 0);
        chk("midrst_valid", int'(dds.valid), 0);
        chk("midrst_cycle", int'(dds.cycle), 0);
        step();
        step();
        rst = 1'b0;

        // Unit step over two full periods.
        pulses = 0;
        dds.tuning_word = 16'd256;
        dds.en = 1'b1;
        step();
        step();
        chk("t2_first", int'(dds.sample), 25);
        repeat (510) step();
        dds.en = 1'b0;
        repeat (2) step();
        chk("t2_pulses", pulses, 1);

        // Tick-gated at four bins per sample.
        dds.clr = 1'b1;
        step();
        dds.clr = 1'b0;
        dds.tuning_word = 16'd1024;
        for (int i = 0; i < 70; i++) begin
            dds.en = 1'b1;
            step();
            dds.en = 1'b0;
            repeat (9) step();
        end

        // Quarter-period offset.
        dds.clr = 1'b1;
        step();
        dds.clr = 1'b0;
        dds.phase_offset = 16'd16384;
        dds.tuning_word = 16'd256;
        dds.en = 1'b1;
        step();
        step();
        chk("t4_first", int'(dds.sample), 2047);
        repeat (298) step();
        dds.en = 1'b0;
        repeat (2) step();

        // clr colliding with en mid-stream.
        dds.phase_offset = '0;
        dds.en = 1'b1;
        repeat (30) step();
        dds.clr = 1'b1;
        step();
        dds.clr = 1'b0;
        chk("t5_drop1", int'(dds.valid), 0);
        step();
        chk("t5_drop2", int'(dds.valid), 0);
        dds.en = 1'b0;
        step();
        chk("t5_valid", int'(dds.valid), 1);
        chk("t5_sample", int'(dds.sample), 25);
        chk("t5_cycle", int'(dds.cycle), 0);

        // Retune from 256 to 4096 while streaming.
        dds.clr = 1'b1;
        step();
        dds.clr = 1'b0;
        dds.tuning_word = 16'd256;
        dds.en = 1'b1;
        repeat (10) step();
        pulses = 0;
        dds.tuning_word = 16'd4096;
        repeat (40) step();
        dds.en = 1'b0;
        repeat (2) step();
        chk("t6_pulses", pulses, 2);

        // Random traffic, including zero tuning words and a mid-run reset.
        for (int i = 0; i < 1500; i++) begin
            dds.en = ($urandom_range(0, 3) != 0);
            dds.clr = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 30) == 0)
                dds.tuning_word = ($urandom_range(0, 4) == 0) ? '0 : PW'($urandom);
            if ($urandom_range(0, 30) == 0)
                dds.phase_offset = PW'($urandom);
            if (i == 700) rst = 1'b1;
            if (i == 702) rst = 1'b0;
            step();
        end
        dds.en = 1'b0;
        dds.clr = 1'b0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
